// File: rtl/pipe_regs_pkg.sv
// Shared constants for the pipe_regs register pipeline.
// Holds only the default data width and the largest supported stage count.
package pipe_regs_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int MAX_DEPTH     = 8;
endpackage

// File: rtl/pipe_regs_if.sv
// Valid/ready bus of the register pipeline, plus flush and occupancy sideband.
// The slave modport is the pipeline's view; the master modport is the producer/consumer view.
interface pipe_regs_if
  import pipe_regs_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 2
) ();
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage.sv
// One pipeline stage: data register plus valid bit; holds when not advancing.
// Data only loads when the incoming word is valid; flush clears valid but keeps data.
module pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             advance,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d,
  output logic             q_valid,
  output logic [WIDTH-1:0] q
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (advance) begin
      valid_d = d_valid;
      if (d_valid) data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign q_valid = valid_q;
  assign q       = data_q;
endmodule

// File: rtl/pipe_regs.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse; DEPTH cycles latency, 1 word/cycle.
// Backpressure: in_ready is combinational from out_ready and the stage valid bits only.
module pipe_regs
  import pipe_regs_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic        clk,
  input  logic        rst,
  pipe_regs_if.slave  bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_depth_check
    $error("pipe_regs: DEPTH must be in 1..8");
  end

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];
  logic             in_xfer, out_xfer;
  logic [OCC_W-1:0] occ_q, occ_d;

  // A stage may advance unless it and every stage downstream of it are full
  // while the consumer stalls; written flat to avoid a chained comb loop.
  for (genvar i = 0; i < DEPTH; i++) begin : g_adv
    assign adv[i] = bus.out_ready | ~(&vld[DEPTH-1:i]);
  end

  assign bus.in_ready = adv[0] & ~bus.flush & ~rst;
  assign in_xfer      = bus.in_valid & bus.in_ready;
  assign out_xfer     = vld[DEPTH-1] & bus.out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .advance (adv[0]),
        .d_valid (in_xfer),
        .d       (bus.in_data),
        .q_valid (vld[0]),
        .q       (dat[0])
      );
    end else begin : g_rest
      pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .advance (adv[i]),
        .d_valid (vld[i-1]),
        .d       (dat[i-1]),
        .q_valid (vld[i]),
        .q       (dat[i])
      );
    end
  end

  always_comb begin
    occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    if (bus.flush) occ_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign bus.out_valid = vld[DEPTH-1];
  assign bus.out_data  = dat[DEPTH-1];
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_pipe_regs.sv
// Scoreboarded bench for pipe_regs at DEPTH 1, 2 (RESET_VAL 0xDEADBEEF) and 3.
// Directed vectors drive the pipelines; a negedge monitor checks order and stall stability.
module tb_pipe_regs;
  import pipe_regs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2, rst3;
  int   checks = 0;
  int   fails  = 0;

  pipe_regs_if #(.WIDTH(32), .DEPTH(1)) if1 ();
  pipe_regs_if #(.WIDTH(32), .DEPTH(2)) if2 ();
  pipe_regs_if #(.WIDTH(32), .DEPTH(3)) if3 ();

  pipe_regs #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'h0)) u1 (
    .clk(clk), .rst(rst1), .bus(if1.slave));
  pipe_regs #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'hDEADBEEF)) u2 (
    .clk(clk), .rst(rst2), .bus(if2.slave));
  pipe_regs #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0)) u3 (
    .clk(clk), .rst(rst3), .bus(if3.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor view of the three instances (index 0/1/2 = DEPTH 1/2/3).
  logic        m_rst[3], m_flush[3], m_iv[3], m_ir[3], m_ov[3], m_or[3];
  logic [31:0] m_id[3], m_od[3];
  always_comb begin
    m_rst[0] = rst1; m_flush[0] = if1.flush; m_iv[0] = if1.in_valid; m_ir[0] = if1.in_ready;
    m_ov[0] = if1.out_valid; m_or[0] = if1.out_ready; m_id[0] = if1.in_data; m_od[0] = if1.out_data;
    m_rst[1] = rst2; m_flush[1] = if2.flush; m_iv[1] = if2.in_valid; m_ir[1] = if2.in_ready;
    m_ov[1] = if2.out_valid; m_or[1] = if2.out_ready; m_id[1] = if2.in_data; m_od[1] = if2.out_data;
    m_rst[2] = rst3; m_flush[2] = if3.flush; m_iv[2] = if3.in_valid; m_ir[2] = if3.in_ready;
    m_ov[2] = if3.out_valid; m_or[2] = if3.out_ready; m_id[2] = if3.in_data; m_od[2] = if3.out_data;
  end

  logic [31:0] sb [3][$];
  logic        stall_q [3];
  logic [31:0] held_q  [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (m_rst[k]) begin
        sb[k].delete();
        stall_q[k] = 1'b0;
      end else begin
        if (stall_q[k]) begin
          chk($sformatf("d%0d_stall_valid", k + 1), 32'(m_ov[k]), 32'd1);
          chk($sformatf("d%0d_stall_data", k + 1), m_od[k], held_q[k]);
        end
        if (m_ov[k] && m_or[k]) begin
          if (sb[k].size() == 0)
            chk($sformatf("d%0d_sb_underflow", k + 1), 32'(sb[k].size()), 32'd1);
          else
            chk($sformatf("d%0d_sb_order", k + 1), m_od[k], sb[k].pop_front());
        end
        if (m_iv[k] && m_ir[k]) sb[k].push_back(m_id[k]);
        if (m_flush[k]) sb[k].delete();
        stall_q[k] = m_ov[k] && !m_or[k] && !m_flush[k];
        held_q[k]  = m_od[k];
      end
    end
  end

  int mocc;
  logic exp_rdy;

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    if1.flush = 0; if1.in_valid = 0; if1.in_data = 0; if1.out_ready = 0;
    if2.flush = 0; if2.in_valid = 0; if2.in_data = 0; if2.out_ready = 0;
    if3.flush = 0; if3.in_valid = 0; if3.in_data = 0; if3.out_ready = 0;
    step(); step();

    // Reset state
    chk("rst_out_valid", 32'(if2.out_valid), 32'd0);
    chk("rst_out_data", if2.out_data, 32'hDEADBEEF);
    chk("rst_occ", 32'(if2.occupancy), 32'd0);
    chk("rst_in_ready", 32'(if2.in_ready), 32'd0);
    chk("rst_d3_occ", 32'(if3.occupancy), 32'd0);
    rst1 = 0; rst2 = 0; rst3 = 0;
    step();

    // DEPTH=2 streaming, latency 2, data held when incoming valid is 0
    if2.out_ready = 1; if2.in_valid = 1; if2.in_data = 32'h1; #1;
    chk("stream_rdy0", 32'(if2.in_ready), 32'd1);
    step(); if2.in_data = 32'h2; #1;
    chk("stream_rdy1", 32'(if2.in_ready), 32'd1);
    chk("stream_lat_ov", 32'(if2.out_valid), 32'd0);
    step(); if2.in_data = 32'h3; #1;
    chk("stream_rdy2", 32'(if2.in_ready), 32'd1);
    chk("stream_ov1", 32'(if2.out_valid), 32'd1);
    chk("stream_d1", if2.out_data, 32'h1);
    step(); if2.in_valid = 0; if2.in_data = 32'hFFFF_FFFF; #1;
    chk("stream_d2", if2.out_data, 32'h2);
    step(); #1;
    chk("stream_d3", if2.out_data, 32'h3);
    step(); #1;
    chk("stream_empty", 32'(if2.out_valid), 32'd0);
    chk("stream_occ0", 32'(if2.occupancy), 32'd0);
    chk("stream_hold", if2.out_data, 32'h3);

    // DEPTH=2 flush while full, output transfer in the flush cycle
    if2.out_ready = 0; if2.in_valid = 1; if2.in_data = 32'h11;
    step(); if2.in_data = 32'h22;
    step(); if2.in_valid = 0; #1;
    chk("full_rdy", 32'(if2.in_ready), 32'd0);
    chk("full_occ", 32'(if2.occupancy), 32'd2);
    chk("full_head", if2.out_data, 32'h11);
    if2.flush = 1; if2.out_ready = 1; if2.in_valid = 1; if2.in_data = 32'h33; #1;
    chk("flush_rdy", 32'(if2.in_ready), 32'd0);
    chk("flush_ov", 32'(if2.out_valid), 32'd1);
    step(); if2.flush = 0; if2.in_valid = 0; #1;
    chk("flush_after_ov", 32'(if2.out_valid), 32'd0);
    chk("flush_after_occ", 32'(if2.occupancy), 32'd0);
    chk("flush_data_hold", if2.out_data, 32'h11);

    // DEPTH=2 reset mid-stream with flush asserted
    if2.out_ready = 0; if2.in_valid = 1; if2.in_data = 32'h44;
    step(); if2.in_data = 32'h55; #1;
    chk("mid_rdy", 32'(if2.in_ready), 32'd1);
    rst2 = 1; if2.flush = 1; #1;
    chk("mid_rst_rdy", 32'(if2.in_ready), 32'd0);
    step(); #1;
    chk("mid_rst_ov", 32'(if2.out_valid), 32'd0);
    chk("mid_rst_data", if2.out_data, 32'hDEADBEEF);
    chk("mid_rst_occ", 32'(if2.occupancy), 32'd0);
    chk("mid_rst_rdy2", 32'(if2.in_ready), 32'd0);
    rst2 = 0; if2.flush = 0; if2.in_valid = 0; #1;
    chk("post_rst_rdy", 32'(if2.in_ready), 32'd1);
    step();

    // DEPTH=3 fill under stall, then drain in order
    if3.out_ready = 0; if3.in_valid = 1; if3.in_data = 32'hA; #1;
    chk("d3_rdyA", 32'(if3.in_ready), 32'd1);
    step(); if3.in_data = 32'hB;
    step(); if3.in_data = 32'hC;
    step(); if3.in_data = 32'hD; #1;
    chk("d3_full_rdy", 32'(if3.in_ready), 32'd0);
    chk("d3_full_occ", 32'(if3.occupancy), 32'd3);
    chk("d3_full_head", if3.out_data, 32'hA);
    step(); #1;
    chk("d3_stall_head", if3.out_data, 32'hA);
    chk("d3_stall_rdy", 32'(if3.in_ready), 32'd0);
    if3.out_ready = 1; #1;
    chk("d3_release_rdy", 32'(if3.in_ready), 32'd1);
    step(); if3.in_valid = 0; #1;
    chk("d3_B", if3.out_data, 32'hB);
    step(); #1;
    chk("d3_C", if3.out_data, 32'hC);
    step(); #1;
    chk("d3_D", if3.out_data, 32'hD);
    step(); #1;
    chk("d3_drained", 32'(if3.out_valid), 32'd0);

    // DEPTH=3 bubble collapse: only the last stage valid, consumer stalled
    if3.out_ready = 0; if3.in_valid = 1; if3.in_data = 32'h5;
    step(); if3.in_valid = 0;
    step(); step(); #1;
    chk("bub_occ1", 32'(if3.occupancy), 32'd1);
    chk("bub_head", if3.out_data, 32'h5);
    chk("bub_ov", 32'(if3.out_valid), 32'd1);
    if3.in_valid = 1; if3.in_data = 32'h6; #1;
    chk("bub_rdy", 32'(if3.in_ready), 32'd1);
    step(); if3.in_valid = 0; #1;
    chk("bub_occ2", 32'(if3.occupancy), 32'd2);
    chk("bub_head2", if3.out_data, 32'h5);
    step(); #1;
    chk("bub_occ2b", 32'(if3.occupancy), 32'd2);
    chk("bub_head3", if3.out_data, 32'h5);
    if3.out_ready = 1;
    step(); step(); step(); #1;
    chk("bub_occ0", 32'(if3.occupancy), 32'd0);

    // DEPTH=1 random traffic against a count model
    mocc = 0;
    for (int n = 0; n < 10000; n++) begin
      if1.in_valid  = 1'($urandom_range(0, 1));
      if1.out_ready = ($urandom_range(0, 3) != 0);
      if1.in_data   = 32'(n) ^ 32'hA5A5_0000;
      #1;
      exp_rdy = if1.out_ready || (mocc == 0);
      chk("d1_in_ready", 32'(if1.in_ready), 32'(exp_rdy));
      chk("d1_occ", 32'(if1.occupancy), 32'(mocc));
      chk("d1_out_valid", 32'(if1.out_valid), 32'(mocc != 0));
      mocc = mocc + int'(if1.in_valid && exp_rdy) - int'(if1.out_ready && mocc != 0);
      step();
    end
    if1.in_valid = 0; if1.out_ready = 1;
    step(); step(); step();

    chk("d1_sb_empty", 32'(sb[0].size()), 32'd0);
    chk("d2_sb_empty", 32'(sb[1].size()), 32'd0);
    chk("d3_sb_empty", 32'(sb[2].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pipe_regs.md
PIPE_REGS -- requirements
Module: pipe_regs

Interface
REQ-001 Parameter WIDTH, default 32, data bits per stage.
REQ-002 Parameter DEPTH, default 2, number of register stages; legal range 1..8.
REQ-003 Parameter RESET_VAL, default 0, data value loaded into every stage on reset.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 flush  input  1  synchronous pipeline clear request.
REQ-007 in_valid  input  1  upstream word valid.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  upstream word.
REQ-010 out_valid  output  1  stage DEPTH-1 holds a valid word.
REQ-011 out_ready  input  1  downstream accepts this cycle.
REQ-012 out_data  output  WIDTH  data of stage DEPTH-1.
REQ-013 occupancy  output  clog2(DEPTH+1)  registered count of valid stages.

Function
REQ-014 Each stage i SHALL hold a data register and a valid bit; stage 0 faces input, stage DEPTH-1 drives out_valid/out_data directly from registers.
REQ-015 Stage DEPTH-1 advances when out_ready=1 or its valid=0; stage i<DEPTH-1 advances when stage i+1 advances or its own valid=0 (bubble collapse).
REQ-016 in_ready SHALL equal "stage 0 advances" AND NOT flush; combinational from out_ready and valid bits only, never from in_valid.
REQ-017 Input transfer occurs when in_valid=1 and in_ready=1; output transfer occurs when out_valid=1 and out_ready=1.
REQ-018 On an advancing stage, data and valid load from the previous stage (stage 0 from in_data/in_valid AND in_ready); a non-advancing stage SHALL hold data and valid unchanged.
REQ-019 Stage data registers SHALL NOT change when the incoming valid is 0 (valid clears, data held).
REQ-020 Latency with no stall: word accepted at edge N appears on out_data with out_valid=1 after edge N+DEPTH-1, i.e. visible DEPTH cycles after presentation.
REQ-021 Throughput: one word per cycle sustained while out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_valid SHALL remain stable until transfer or flush/reset.
REQ-023 Full (all valid, out_ready=0): in_ready=0, no state change.
REQ-024 flush=1: at the next edge all valid bits SHALL clear, data registers hold; an output transfer in the flush cycle still counts as completed; no input transfer occurs.
REQ-025 occupancy SHALL update every edge to the number of valid stages after that edge; range 0..DEPTH, never wraps.
REQ-026 Words SHALL leave in arrival order; no word duplicated or dropped except by flush/reset.

Reset
REQ-027 rst=1 at an edge: all valid bits 0, all data = RESET_VAL, occupancy 0; out_valid=0, out_data=RESET_VAL after that edge.
REQ-028 rst SHALL take priority over flush and any handshake in the same cycle; reset mid-stream discards all words.
REQ-029 While rst=1, in_ready SHALL be 0.

Structure
REQ-030 Shared header constants: default WIDTH (32, machine word) and max DEPTH (8); no other shared definitions.
REQ-031 One sub-module pipe_stage (parameters WIDTH, RESET_VAL; ports clk, rst, flush, advance, d_valid, d, q_valid, q) instantiated DEPTH times via generate; advance chain and occupancy counter live in pipe_regs.
REQ-032 Parameter DEPTH outside 1..8 SHALL be rejected at elaboration.

Verification
REQ-033 DEPTH=2, out_ready=1, in_valid=1 streaming 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on consecutive cycles, first 2 cycles after presentation, in_ready=1 throughout.
REQ-034 DEPTH=3, out_ready=0, push 0xA,0xB,0xC,0xD -> first three accepted, occupancy 3, in_ready=0 on 0xD; out_data=0xA stable; raise out_ready -> 0xA,0xB,0xC then 0xD in order.
REQ-035 DEPTH=3, only stage 2 valid (0x5), out_ready=0, push 0x6 -> accepted (bubble collapse), occupancy 2, out_data stays 0x5.
REQ-036 DEPTH=2, full with 0x11,0x22, flush=1 with out_ready=1, in_valid=1 -> 0x11 transfers that cycle, in_ready=0, next cycle out_valid=0, occupancy 0.
REQ-037 RESET_VAL=0xDEADBEEF, rst=1 mid-stream with flush=1 -> after edge out_valid=0, out_data=0xDEADBEEF, occupancy 0, in_ready=0 while rst=1.
REQ-038 DEPTH=1, random in_valid/out_ready for 10000 cycles -> scoreboard order match, no loss, out_data stable under stall.
